axi_write_error_responder: RTL
==============================

# axi_write_error_responder

Write-side error responder for the AXI node. It is the counterpart of the AW address decoder's error handshake. When the decoder flags an unmapped or unconnected write address, this block captures the AW attributes and drains the matching W burst. It then returns a single DECERR write response on the B channel and signals completion back to the decoder.

## Interface
Parameters:
- AXI_ID_WIDTH, default 4: width of the AW/B transaction ID.
- AXI_USER_WIDTH, default 6: width of the AW/B user sideband.
- AXI_LEN_WIDTH, default 8: width of AWLEN (beats = awlen+1).

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - clk  input  1  block clock, all state on rising edge.
  - rst  input  1  asynchronous, active-high reset.
- AW capture from the decoder:
  - sample_awdata_info_i  input  1  capture strobe for the errored AW attributes.
  - awid_i  input  AXI_ID_WIDTH  ID of the errored AW.
  - awlen_i  input  AXI_LEN_WIDTH  burst length of the errored AW.
  - awuser_i  input  AXI_USER_WIDTH  user sideband of the errored AW.
- W drain handshake:
  - handle_error_i  input  1  decoder grants W-channel ownership for the drain.
  - wdata_error_completed_o  output  1  one-cycle pulse: the errored W burst is fully drained.
  - wvalid_i  input  1  W beat valid.
  - wlast_i  input  1  W last beat.
  - wready_o  output  1  W beat accept.
  - len_error_o  output  1  one-cycle pulse: the drained beat count differs from awlen+1.
- B response:
  - error_req_i  input  1  decoder requests issue of the error B response.
  - error_gnt_o  output  1  B response handshake completed; the decoder returns to operative.
  - bvalid_o  output  1  B valid.
  - bready_i  input  1  B ready.
  - bid_o  output  AXI_ID_WIDTH  captured AW ID.
  - bresp_o  output  2  fixed at DECERR (2'b11) while bvalid_o is high, otherwise 2'b00.
  - buser_o  output  AXI_USER_WIDTH  captured AW user sideband.

## Operation
The FSM has five states: IDLE, ARMED, DRAIN, WAIT_REQ and RESP.

- **IDLE:**
  - sample_awdata_info_i=1 loads id/len/user registers and moves to ARMED.
  - handle_error_i or error_req_i without a prior sample is ignored; the block stays in IDLE.
- **ARMED:**
  - handle_error_i=1 moves to DRAIN and clears the beat counter.
  - sample_awdata_info_i is ignored here; the capture registers are written only in IDLE.
- **DRAIN:**
  - wready_o=1. Every wvalid_i&wready_o increments a saturating beat counter, AXI_LEN_WIDTH+1 bits wide.
  - A beat with wlast_i=1 ends the burst and moves to WAIT_REQ.
  - On that transition the counter is compared with awlen+1, with both operands zero-extended to AXI_LEN_WIDTH+1 bits. A mismatch raises len_error_o.
  - Termination is on wlast_i only, never on the count.
- **WAIT_REQ:**
  - wready_o=0.
  - error_req_i=1 moves to RESP.
- **RESP:**
  - bvalid_o=1 with bid_o and buser_o driven from the capture registers and bresp_o=DECERR.
  - bvalid_o holds, with stable payload, until bready_i=1.
  - error_gnt_o = bvalid_o & bready_i, combinational, high for exactly that cycle. The state then returns to IDLE.
- Only one errored transaction is in flight at a time. The decoder stalls AW while the responder is busy, so no queueing is provided.

## Timing
- Reset: the state is IDLE and every output is 0. The capture registers and beat counter are cleared.
- Reset asserted mid-operation (any state) aborts immediately to IDLE. A partial burst is not completed and no B is issued.
- wready_o and bvalid_o are decoded from registered state only; there is no combinational path from inputs.
- Fastest flow, by cycle:
  - Cycle 0: sample strobe.
  - Cycle 1: ARMED.
  - Cycle 1 + k: handle_error_i seen.
  - Next cycle: DRAIN, W beats accepted one per cycle.
  - Cycle after the wlast beat: WAIT_REQ with wdata_error_completed_o=1.
  - Cycle after error_req_i: bvalid_o=1.
- The wlast beat and the completion pulse: the pulse is registered and asserted in the first WAIT_REQ cycle. len_error_o has identical timing.
- error_req_i already high on WAIT_REQ entry gives bvalid_o one cycle later.
- bready_i already high when bvalid_o rises completes the handshake in that same cycle.
- awlen_i=0 with a single wlast beat is a 1-beat drain with no error.
- Beat counter saturation at 2^AXI_LEN_WIDTH+... is held at its maximum value; len_error_o then pulses.

## Structure
- Shared package axi_node_pkg holds:
  - AXI_RESP_OKAY=2'b00 and AXI_RESP_DECERR=2'b11.
  - The FSM state enum type (3 bits).
- No sub-module is needed: the FSM, capture registers and counter sit in a single module, roughly 150–200 lines.

## Test plan
- **Nominal drain:** sample id=5, len=3, user=0x2A, then handle_error_i. Drive 4 W beats with wlast on the 4th, then error_req_i with bready=1.
  - Required: wready only in DRAIN; completion pulse one cycle after beat 4; len_error_o=0.
  - Required: bvalid with bid=5, buser=0x2A, bresp=2'b11; error_gnt_o is a 1-cycle pulse.
- **Early wlast:** len=7 with wlast on beat 3. Required: drain ends after beat 3 and len_error_o pulses once.
- **B backpressure:** bready=0 for 5 cycles. Required: bvalid stays high with a stable payload, error_gnt_o stays 0, then pulses once on the first bready=1 cycle.
- **Spurious controls:** handle_error_i and error_req_i asserted in IDLE with no sample. Required: no wready, no bvalid, state stays IDLE.
- **Reset mid-drain:** assert rst after 2 of 4 beats. Required: all outputs go to 0 asynchronously, the block is in IDLE after release, and no B is issued.
- **Single-beat burst:** len=0 with one wlast beat and bursty wvalid gaps. Required: gaps are tolerated, there is no len_error, and a correct B follows.

Source files
------------

// File: rtl/axi_node_pkg.sv
// Shared AXI node definitions: response codes and the error responder FSM state type.
package axi_node_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_WAIT_REQ = 3'd3,
    ST_RESP     = 3'd4
  } err_state_e;

endpackage

// File: rtl/axi_write_error_responder.sv
// Write-side error responder: captures an errored AW, drains its W burst and
// returns a single DECERR B response, handshaking with the AW decoder.
module axi_write_error_responder
  import axi_node_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_LEN_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_awdata_info_i,
  input  logic [AXI_ID_WIDTH-1:0]   awid_i,
  input  logic [AXI_LEN_WIDTH-1:0]  awlen_i,
  input  logic [AXI_USER_WIDTH-1:0] awuser_i,
  input  logic                      handle_error_i,
  output logic                      wdata_error_completed_o,
  input  logic                      wvalid_i,
  input  logic                      wlast_i,
  output logic                      wready_o,
  output logic                      len_error_o,
  input  logic                      error_req_i,
  output logic                      error_gnt_o,
  output logic                      bvalid_o,
  input  logic                      bready_i,
  output logic [AXI_ID_WIDTH-1:0]   bid_o,
  output logic [1:0]                bresp_o,
  output logic [AXI_USER_WIDTH-1:0] buser_o,
  output err_state_e                state_dbg
);

  // Handshakes: a W beat transfers when wvalid_i & wready_o; the B response
  // transfers when bvalid_o & bready_i. wready_o/bvalid_o never depend on inputs.

  localparam int CNT_W = AXI_LEN_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  err_state_e state, state_next;

  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [AXI_LEN_WIDTH-1:0]  len_q;
  logic [AXI_USER_WIDTH-1:0] user_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [CNT_W-1:0]          cnt_inc;
  logic [CNT_W-1:0]          len_plus1;
  logic                      completed_q;
  logic                      len_error_q;
  logic                      w_hs;
  logic                      last_hs;

  assign wready_o  = (state == ST_DRAIN);
  assign bvalid_o  = (state == ST_RESP);
  assign w_hs      = wready_o & wvalid_i;
  assign last_hs   = w_hs & wlast_i;
  // Count saturates so an overlong burst can never wrap back onto awlen+1.
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign len_plus1 = {1'b0, len_q} + CNT_W'(1);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (sample_awdata_info_i) state_next = ST_ARMED;
      ST_ARMED:    if (handle_error_i)       state_next = ST_DRAIN;
      ST_DRAIN:    if (last_hs)              state_next = ST_WAIT_REQ;
      ST_WAIT_REQ: if (error_req_i)          state_next = ST_RESP;
      ST_RESP:     if (bready_i)             state_next = ST_IDLE;
      default:                               state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q        <= '0;
      len_q       <= '0;
      user_q      <= '0;
      cnt_q       <= '0;
      completed_q <= 1'b0;
      len_error_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && sample_awdata_info_i) begin
        id_q   <= awid_i;
        len_q  <= awlen_i;
        user_q <= awuser_i;
      end
      if (state == ST_ARMED && handle_error_i) cnt_q <= '0;
      else if (w_hs)                           cnt_q <= cnt_inc;
      // The final beat itself is included in the comparison.
      completed_q <= last_hs;
      len_error_q <= last_hs && (cnt_inc != len_plus1);
    end
  end

  assign wdata_error_completed_o = completed_q;
  assign len_error_o             = len_error_q;
  assign error_gnt_o             = bvalid_o & bready_i;
  assign bid_o                   = bvalid_o ? id_q : '0;
  assign buser_o                 = bvalid_o ? user_q : '0;
  assign bresp_o                 = bvalid_o ? AXI_RESP_DECERR : AXI_RESP_OKAY;
  assign state_dbg               = state;

endmodule
